// File: rtl/apb_rr_master_sequencer.sv
// ---------------------------------------------------------------------------
// apb_rr_master_sequencer
//
// Shares a single APB master port between NUM_REQ requesters. A round-robin
// arbiter picks one requester while the port is idle. The block then runs the
// APB SETUP/ACCESS sequence with the request fields latched at grant time. A
// one-cycle response carrying read data and error status goes back to the
// granted requester. A watchdog aborts an ACCESS phase that never sees PREADY.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i / gnt_o          per-requester request (held until grant) and
//                          one-hot combinational grant (only while idle)
//   addr_i, we_i, wdata_i  flattened per-requester transfer fields
//   rsp_valid_o            one-hot single-cycle response pulse
//   rsp_rdata_o, rsp_err_o shared response data/error, zero when no pulse
//   busy_o                 high whenever a transfer is in SETUP or ACCESS
//   paddr_o .. penable_o   APB master request signals
//   prdata_i, pready_i,    APB completer response signals
//   pslverr_i
// ---------------------------------------------------------------------------
module apb_rr_master_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                               rsp_err_o,
  output logic                               busy_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
  output logic                               pwrite_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  output logic                               psel_o,
  output logic                               penable_o,
  input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
  input  logic                               pready_i,
  input  logic                               pslverr_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // A disabled watchdog still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic WDOG_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           ptr_q;
  logic [IDX_W-1:0]           idx_q;
  logic [APB_ADDR_WIDTH-1:0]  addr_q;
  logic                       we_q;
  logic [APB_DATA_WIDTH-1:0]  wdata_q;
  logic [CNT_W-1:0]           wd_cnt_q;
  logic [NUM_REQ-1:0]         rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                       rsp_err_q;

  logic                       gnt_found;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       timeout_hit;

  // Modular add for requester indices; base < NUM_REQ and off < NUM_REQ,
  // so a single conditional subtraction is enough to wrap.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    int sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: the first active request at or after the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_i[wrap_add(ptr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  // The watchdog fires on the last permitted ACCESS cycle. A PREADY in that
  // same cycle takes priority, so the abort is masked by pready_i.
  assign timeout_hit = WDOG_EN && !pready_i && (wd_cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. The grant is masked while reset is asserted so that every
  // output reads zero during reset, even with requests pending.
  always_comb begin
    gnt_o     = '0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    busy_o    = 1'b0;
    case (state_q)
      IDLE:    if (gnt_found && rst_ni) gnt_o = onehot(gnt_idx);
      SETUP: begin
        psel_o = 1'b1;
        busy_o = 1'b1;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        busy_o    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch the granted request, advance the pointer, run the
  // watchdog, and register the single-cycle response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wd_cnt_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            idx_q    <= gnt_idx;
            addr_q   <= addr_i[32'(gnt_idx) * APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            we_q     <= we_i[gnt_idx];
            wdata_q  <= wdata_i[32'(gnt_idx) * APB_DATA_WIDTH +: APB_DATA_WIDTH];
            ptr_q    <= wrap_add(gnt_idx, 1);
            wd_cnt_q <= '0;
          end
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_valid_q <= onehot(idx_q);
            rsp_rdata_q <= we_q ? '0 : prdata_i;
            rsp_err_q   <= pslverr_i;
          end else if (timeout_hit) begin
            rsp_valid_q <= onehot(idx_q);
            rsp_err_q   <= 1'b1;
          end else if (WDOG_EN) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign paddr_o     = addr_q;
  assign pwrite_o    = we_q;
  assign pwdata_o    = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master_sequencer
//
// Self-checking bench for apb_rr_master_sequencer (NUM_REQ=4, 12-bit
// address, 32-bit data, watchdog limit 8). Each request carries the slave
// behaviour for its transfer: wait states, error flag and read data. The
// reference model tracks transfers as a timeline counted from the grant:
// grant at t=0, SETUP at t=1, ACCESS from t=2, and the response one cycle
// after completion or watchdog abort. The model predicts every output
// cycle by cycle.
// ---------------------------------------------------------------------------
module tb_apb_rr_master_sequencer;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NR-1:0]     req_i;
  logic [NR-1:0]     gnt_o;
  logic [NR*AW-1:0]  addr_i;
  logic [NR-1:0]     we_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR-1:0]     rsp_valid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic              rsp_err_o;
  logic              busy_o;
  logic [AW-1:0]     paddr_o;
  logic              pwrite_o;
  logic [DW-1:0]     pwdata_o;
  logic              psel_o;
  logic              penable_o;
  logic [DW-1:0]     prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  apb_rr_master_sequencer #(
    .NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .psel_o(psel_o), .penable_o(penable_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  int check_count = 0;
  int error_count = 0;

  // Pending requests, one slot per requester, with the slave plan attached.
  logic [NR-1:0] pend;
  logic [AW-1:0] p_addr  [NR];
  logic          p_we    [NR];
  logic [DW-1:0] p_wdata [NR];
  int            p_waits [NR];
  logic          p_err   [NR];
  logic [DW-1:0] p_rdata [NR];

  // Transfer in flight: xt counts cycles since its grant.
  int            ptr;
  logic          active;
  int            xt;
  int            x_idx;
  logic [AW-1:0] x_addr;
  logic          x_we;
  logic [DW-1:0] x_wdata;
  int            x_waits;
  logic          x_err;
  logic [DW-1:0] x_rdata;

  logic [NR-1:0] exp_rsp_valid;
  logic [DW-1:0] exp_rsp_rdata;
  logic          exp_rsp_err;
  int            win;
  logic          refill_all;
  logic          random_traffic;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    ptr           = 0;
    active        = 1'b0;
    xt            = 0;
    pend          = '0;
    exp_rsp_valid = '0;
    exp_rsp_rdata = '0;
    exp_rsp_err   = 1'b0;
    win           = -1;
  endtask

  task automatic newRequest(input int k, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] d, input int waits,
                            input logic err, input logic [DW-1:0] rd);
    pend[k]    = 1'b1;
    p_addr[k]  = a;
    p_we[k]    = w;
    p_wdata[k] = d;
    p_waits[k] = waits;
    p_err[k]   = err;
    p_rdata[k] = rd;
  endtask

  // Mostly short wait states, plus the pready/timeout tie (7 waits puts
  // PREADY on the 8th ACCESS cycle) and genuine timeouts.
  task automatic randomRequest(input int k);
    int r;
    int waits;
    r = int'($urandom % 10);
    case (r)
      6:       waits = 7;
      7:       waits = 6;
      8:       waits = 50;
      9:       waits = 8;
      default: waits = int'($urandom % 4);
    endcase
    newRequest(k, AW'($urandom), 1'($urandom), $urandom, waits,
               1'($urandom % 4 == 0), $urandom);
  endtask

  // Drive requester and slave inputs for the coming cycle. Fields the DUT
  // should ignore get random junk.
  task automatic applyStimulus();
    int acc;
    for (int k = 0; k < NR; k++) begin
      req_i[k]              = pend[k];
      addr_i[k*AW +: AW]    = pend[k] ? p_addr[k]  : AW'($urandom);
      we_i[k]               = pend[k] ? p_we[k]    : 1'($urandom);
      wdata_i[k*DW +: DW]   = pend[k] ? p_wdata[k] : $urandom;
    end
    if (active && xt >= 2) begin
      acc       = xt - 1;
      pready_i  = (acc == x_waits + 1);
      prdata_i  = pready_i ? x_rdata : $urandom;
      pslverr_i = pready_i ? x_err : 1'($urandom);
    end else begin
      pready_i  = 1'($urandom);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
    end
  endtask

  task automatic checkCycle();
    logic [NR-1:0] exp_gnt;
    int c;
    win = -1;
    if (!active) begin
      for (int i = 0; i < NR; i++) begin
        c = (ptr + i) % NR;
        if (win < 0 && pend[c]) win = c;
      end
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    checkOutput("gnt", 64'(gnt_o), 64'(exp_gnt));
    checkOutput("psel", 64'(psel_o), 64'(active));
    checkOutput("penable", 64'(penable_o), 64'(active && xt >= 2));
    checkOutput("busy", 64'(busy_o), 64'(active));
    if (active) begin
      checkOutput("paddr", 64'(paddr_o), 64'(x_addr));
      checkOutput("pwrite", 64'(pwrite_o), 64'(x_we));
      checkOutput("pwdata", 64'(pwdata_o), 64'(x_wdata));
    end
    checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp_valid));
    checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rsp_rdata));
    checkOutput("rsp_err", 64'(rsp_err_o), 64'(exp_rsp_err));
  endtask

  // Advance the model across one rising edge.
  task automatic advanceModel();
    int acc;
    exp_rsp_valid = '0;
    exp_rsp_rdata = '0;
    exp_rsp_err   = 1'b0;
    if (active) begin
      if (xt >= 2) begin
        acc = xt - 1;
        if (acc == x_waits + 1) begin
          exp_rsp_valid[x_idx] = 1'b1;
          exp_rsp_rdata        = x_we ? '0 : x_rdata;
          exp_rsp_err          = x_err;
          active               = 1'b0;
        end else if (acc == TO) begin
          exp_rsp_valid[x_idx] = 1'b1;
          exp_rsp_err          = 1'b1;
          active               = 1'b0;
        end else begin
          xt++;
        end
      end else begin
        xt = 2;
      end
    end
    if (win >= 0) begin
      x_idx     = win;
      x_addr    = p_addr[win];
      x_we      = p_we[win];
      x_wdata   = p_wdata[win];
      x_waits   = p_waits[win];
      x_err     = p_err[win];
      x_rdata   = p_rdata[win];
      pend[win] = 1'b0;
      ptr       = (win + 1) % NR;
      active    = 1'b1;
      xt        = 1;
    end
    for (int k = 0; k < NR; k++) begin
      if (random_traffic && pend[k] && ($urandom % 40 == 0)) pend[k] = 1'b0;
      else if (!pend[k] && (refill_all || (random_traffic && ($urandom % 4 == 0))))
        randomRequest(k);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk_i);
      applyStimulus();
      #1;
      checkCycle();
      advanceModel();
    end
  endtask

  initial begin
    refill_all     = 1'b0;
    random_traffic = 1'b0;
    resetModel();
    rst_ni    = 1'b0;
    req_i     = '0;
    addr_i    = '0;
    we_i      = '0;
    wdata_i   = '0;
    prdata_i  = '0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_gnt", 64'(gnt_o), 64'h0);
    checkOutput("reset_psel", 64'(psel_o), 64'h0);
    checkOutput("reset_penable", 64'(penable_o), 64'h0);
    checkOutput("reset_busy", 64'(busy_o), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 64'h0);
    checkOutput("reset_rsp_rdata", 64'(rsp_rdata_o), 64'h0);
    checkOutput("reset_rsp_err", 64'(rsp_err_o), 64'h0);
    checkOutput("reset_paddr", 64'(paddr_o), 64'h0);
    checkOutput("reset_pwrite", 64'(pwrite_o), 64'h0);
    checkOutput("reset_pwdata", 64'(pwdata_o), 64'h0);
    rst_ni = 1'b1;

    $display("[TB] zero-wait write from requester 0");
    newRequest(0, 12'h010, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    runCycles(5);

    $display("[TB] read with 3 wait states from requester 2");
    newRequest(2, 12'h0A4, 1'b0, 32'h0, 3, 1'b0, 32'h12345678);
    runCycles(8);

    $display("[TB] round-robin with all requests held");
    refill_all = 1'b1;
    for (int k = 0; k < NR; k++) newRequest(k, AW'(k * 16), 1'b1, 32'(k), 0, 1'b0, 32'h0);
    runCycles(15);
    refill_all = 1'b0;
    runCycles(20);

    $display("[TB] slave error on write from requester 1");
    newRequest(1, 12'h100, 1'b1, 32'hA5A5A5A5, 1, 1'b1, 32'h0);
    runCycles(8);

    $display("[TB] watchdog timeout followed by queued request");
    newRequest(3, 12'h300, 1'b0, 32'h0, 100, 1'b0, 32'hBAD0BAD0);
    newRequest(0, 12'h004, 1'b0, 32'h0, 0, 1'b0, 32'h0000FACE);
    runCycles(20);

    $display("[TB] reset in the middle of ACCESS");
    newRequest(2, 12'h0C8, 1'b0, 32'h0, 20, 1'b0, 32'hCAFE0001);
    runCycles(4);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_mid_psel", 64'(psel_o), 64'h0);
    checkOutput("rst_mid_penable", 64'(penable_o), 64'h0);
    checkOutput("rst_mid_busy", 64'(busy_o), 64'h0);
    checkOutput("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'h0);
    resetModel();
    @(posedge clk_i);
    #1;
    checkOutput("rst_hold_rsp_valid", 64'(rsp_valid_o), 64'h0);
    rst_ni = 1'b1;
    newRequest(1, 12'h111, 1'b1, 32'h11111111, 0, 1'b0, 32'h0);
    newRequest(2, 12'h222, 1'b0, 32'h0, 1, 1'b0, 32'h22222222);
    runCycles(12);

    $display("[TB] random traffic");
    random_traffic = 1'b1;
    runCycles(2500);
    random_traffic = 1'b0;
    runCycles(150);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
